// File: rtl/event_counter_bank_if.sv
// Read-port bundle for event_counter_bank.
// The consumer (master) issues rd_req/rd_sel and accepts with rd_ready;
// the counter bank (slave) answers with rd_valid/rd_data.
interface event_counter_bank_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
);
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output rd_req,
        output rd_sel,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_sel,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/event_counter_bank.sv
// event_counter_bank: CHANNELS independent event counters of WIDTH bits with
// sticky overflow flags and a one-deep read port (IDLE/VALID handshake).
// SATURATE=0 wraps to zero on overflow, SATURATE=1 holds at the maximum.
// Optional feature: define EVENT_COUNTER_SNAPSHOT_EN to add a snapshot input
// that copies every counter into a shadow bank; reads then return shadow values.
module event_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [CHANNELS-1:0] events,
`ifdef EVENT_COUNTER_SNAPSHOT_EN
    input  logic                snapshot,
`endif
    event_counter_bank_if.slave rd,
    output logic [CHANNELS-1:0] ovf
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, VALID} rd_state_t;

    rd_state_t        state;
    logic [WIDTH-1:0] count     [CHANNELS];
    logic [WIDTH-1:0] count_nxt [CHANNELS];
    logic             count_hit [CHANNELS];
    logic [WIDTH-1:0] read_src  [CHANNELS];
    logic [WIDTH-1:0] sel_value;

    // Incremented value of one counter; the MSB flags that it was at maximum,
    // the low bits either wrap to zero or stick at maximum.
    function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] res;
        if (cur == CNT_MAX) begin
            res = (SATURATE != 0) ? {1'b1, CNT_MAX} : {1'b1, {WIDTH{1'b0}}};
        end else begin
            res = {1'b0, cur + WIDTH'(1)};
        end
        return res;
    endfunction

    // Per-channel next value and overflow hit, used only when that channel counts
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            {count_hit[i], count_nxt[i]} = count_step(count[i]);
        end
    end

    // Live counters and sticky flags: clear wins, otherwise enable gates counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            ovf <= '0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            ovf <= '0;
        end else if (enable) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (events[i]) begin
                    count[i] <= count_nxt[i];
                    if (count_hit[i]) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef EVENT_COUNTER_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow [CHANNELS];

    // Shadow bank ignores clear, so a same-edge clear still captures the old counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (snapshot) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= count[i];
            end
        end
    end

    // Reads are served from the frozen shadow copy
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            read_src[i] = shadow[i];
        end
    end
`else
    // Reads are served from the live counters
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            read_src[i] = count[i];
        end
    end
`endif

    // Channel mux; selections past the last channel read as zero
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(rd.rd_sel) == i) begin
                sel_value = read_src[i];
            end
        end
    end

    // Read FSM: capture once on request, then hold the word until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd.rd_req) begin
                        state       <= VALID;
                        rd.rd_valid <= 1'b1;
                        rd.rd_data  <= sel_value;
                    end
                end
                VALID: begin
                    if (rd.rd_ready) begin
                        state       <= IDLE;
                        rd.rd_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rd.rd_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_event_counter_bank.sv
// Bench for event_counter_bank: three instances driven in lock-step
//   d0: WIDTH=8, CHANNELS=4, wrap
//   d1: WIDTH=4, CHANNELS=3, wrap (rd_sel=3 is out of range)
//   d2: WIDTH=4, CHANNELS=4, saturate
// A behavioural model predicts counters, flags and read words; read words are
// queued when a request is issued and popped when the DUT raises rd_valid.
module tb_event_counter_bank;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [3:0] events;
    logic       rd_req;
    logic [1:0] rd_sel;
    logic       rd_ready;
`ifdef EVENT_COUNTER_SNAPSHOT_EN
    logic       snapshot;
`endif

    logic [3:0] ovf0;
    logic [2:0] ovf1;
    logic [3:0] ovf2;

    event_counter_bank_if #(.WIDTH(8), .SEL_W(2)) if0 ();
    event_counter_bank_if #(.WIDTH(4), .SEL_W(2)) if1 ();
    event_counter_bank_if #(.WIDTH(4), .SEL_W(2)) if2 ();

    assign if0.rd_req = rd_req;  assign if0.rd_sel = rd_sel;  assign if0.rd_ready = rd_ready;
    assign if1.rd_req = rd_req;  assign if1.rd_sel = rd_sel;  assign if1.rd_ready = rd_ready;
    assign if2.rd_req = rd_req;  assign if2.rd_sel = rd_sel;  assign if2.rd_ready = rd_ready;

    event_counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .events(events),
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot),
`endif
        .rd(if0), .ovf(ovf0)
    );

    event_counter_bank #(.WIDTH(4), .CHANNELS(3), .SATURATE(0)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .events(events[2:0]),
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot),
`endif
        .rd(if1), .ovf(ovf1)
    );

    event_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .events(events),
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot),
`endif
        .rd(if2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    logic [2:0] dvalid;
    logic [7:0] ddata [3];
    logic [3:0] dovf  [3];
    assign dvalid   = {if2.rd_valid, if1.rd_valid, if0.rd_valid};
    assign ddata[0] = if0.rd_data;
    assign ddata[1] = {4'b0, if1.rd_data};
    assign ddata[2] = {4'b0, if2.rd_data};
    assign dovf[0]  = ovf0;
    assign dovf[1]  = {1'b0, ovf1};
    assign dovf[2]  = ovf2;

    localparam int unsigned WMAX [3] = '{255, 15, 15};
    localparam int          NCH  [3] = '{4, 3, 4};
    localparam bit          SAT  [3] = '{1'b0, 1'b0, 1'b1};

    typedef logic [2:0][7:0] exp_t;

    int unsigned mcnt [3][4];
    int unsigned mshd [3][4];
    logic [3:0]  movf [3];
    bit          mvalid;
    bit          was_valid;
    exp_t        exp_q [$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned read_src(input int d, input int ch);
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        return mshd[d][ch];
`else
        return mcnt[d][ch];
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                mcnt[d][ch] = 0;
                mshd[d][ch] = 0;
            end
            movf[d] = '0;
        end
        mvalid    = 1'b0;
        was_valid = 1'b0;
        exp_q.delete();
    endtask

    // Predict the coming edge from the current inputs, take the edge, compare.
    task automatic tick();
        exp_t e;
        if (!mvalid) begin
            if (rd_req) begin
                for (int d = 0; d < 3; d++) begin
                    e[d] = (int'(rd_sel) < NCH[d]) ? 8'(read_src(d, int'(rd_sel))) : 8'd0;
                end
                exp_q.push_back(e);
                mvalid = 1'b1;
            end
        end else if (rd_ready) begin
            mvalid = 1'b0;
        end
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        if (snapshot) begin
            for (int d = 0; d < 3; d++)
                for (int ch = 0; ch < 4; ch++) mshd[d][ch] = mcnt[d][ch];
        end
`endif
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < NCH[d]; ch++) begin
                if (clear) begin
                    mcnt[d][ch] = 0;
                    movf[d][ch] = 1'b0;
                end else if (enable && events[ch]) begin
                    if (mcnt[d][ch] == WMAX[d]) begin
                        movf[d][ch] = 1'b1;
                        mcnt[d][ch] = SAT[d] ? WMAX[d] : 0;
                    end else begin
                        mcnt[d][ch] = mcnt[d][ch] + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if ((|dvalid) && !was_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else cur = exp_q.pop_front();
        end
        was_valid = |dvalid;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("valid_d%0d", d), dvalid[d], mvalid);
            if (mvalid) check($sformatf("data_d%0d", d), ddata[d], cur[d]);
            check($sformatf("ovf_d%0d", d), dovf[d], movf[d]);
        end
    endtask

    task automatic read_raw(input int sel);
        rd_req   = 1'b1;
        rd_sel   = 2'(sel);
        rd_ready = 1'b0;
        tick();
        rd_req   = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    // Reads of current counts; with the shadow bank present, freeze it first.
    task automatic do_read(input int sel);
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
`endif
        read_raw(sel);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; events = '0;
        rd_req = 1'b0; rd_sel = '0; rd_ready = 1'b0;
`ifdef EVENT_COUNTER_SNAPSHOT_EN
        snapshot = 1'b0;
`endif
        model_reset();
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid_d%0d", d), dvalid[d], 0);
            check($sformatf("rst_data_d%0d", d), ddata[d], 0);
            check($sformatf("rst_ovf_d%0d", d), dovf[d], 0);
        end
        reset = 1'b0;

        // Basic counting on alternate channels
        enable = 1'b1; events = 4'b0101;
        repeat (10) tick();
        events = '0;
        do_read(0); check("basic_ch0", cur[0], 10);
        do_read(1); check("basic_ch1", cur[0], 0);
        do_read(2); check("basic_ch2", cur[0], 10);
        check("basic_ovf", ovf0, 0);

        // 17 events on ch1: 4-bit wrap lands on 1, saturating holds at 15
        clear = 1'b1; tick(); clear = 1'b0;
        events = 4'b0010;
        repeat (17) tick();
        events = '0;
        do_read(1);
        check("wrap_ch1", cur[1], 1);
        check("wrap_w8_ch1", cur[0], 17);
        check("sat_ch1", cur[2], 15);
        check("wrap_ovf", ovf1, 3'b010);
        clear = 1'b1; tick(); clear = 1'b0;
        do_read(1);
        check("clr_ch1", cur[1], 0);
        check("clr_ovf", ovf1, 0);

        // 20 events on ch3: saturation; ch3 does not exist on d1
        events = 4'b1000;
        repeat (20) tick();
        events = '0;
        do_read(3);
        check("sat_ch3", cur[2], 15);
        check("sat_ovf3", ovf2[3], 1);
        check("w8_ch3", cur[0], 20);
        check("oob_sel", cur[1], 0);

        // Stall with rd_ready low while counting; repeated requests ignored
        events = 4'b1111;
        rd_req = 1'b1; rd_sel = 2'd2; rd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_sel = 2'(i);
            tick();
        end
        rd_req = 1'b0; rd_ready = 1'b1;
        tick();
        check("valid_fall", dvalid, 0);
        rd_ready = 1'b0;

        // Enable low: counters hold despite events
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1; events = '0;
        do_read(0);
        do_read(2);

        // Clear beats simultaneous events
        events = 4'b1111; clear = 1'b1; tick(); clear = 1'b0; events = '0;
        for (int ch = 0; ch < 4; ch++) begin
            do_read(ch);
            for (int d = 0; d < 3; d++) check($sformatf("clr_all_d%0d", d), cur[d], 0);
        end

        // Reset in the middle of a handshake
        events = 4'b1111; repeat (3) tick(); events = '0;
        rd_req = 1'b1; rd_sel = 2'd0; tick(); rd_req = 1'b0;
        reset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async_valid_d%0d", d), dvalid[d], 0);
            check($sformatf("async_data_d%0d", d), ddata[d], 0);
            check($sformatf("async_ovf_d%0d", d), dovf[d], 0);
        end
        model_reset();
        #1;
        reset = 1'b0;
        repeat (3) tick();
        events = 4'b0100; repeat (2) tick(); events = '0;
        do_read(2);
        check("post_rst_ch2", cur[0], 2);

`ifdef EVENT_COUNTER_SNAPSHOT_EN
        // Shadow bank: reads see the last snapshot, clear leaves it alone
        clear = 1'b1; tick(); clear = 1'b0;
        events = 4'b0001; repeat (7) tick(); events = '0;
        snapshot = 1'b1; tick(); snapshot = 1'b0;
        events = 4'b0001; repeat (3) tick(); events = '0;
        read_raw(0); check("snap_first", cur[0], 7);
        snapshot = 1'b1; tick(); snapshot = 1'b0;
        read_raw(0); check("snap_second", cur[0], 10);
        events = 4'b0001; repeat (2) tick(); events = '0;
        snapshot = 1'b1; clear = 1'b1; tick(); snapshot = 1'b0; clear = 1'b0;
        read_raw(0); check("snap_vs_clear", cur[0], 12);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
